coef_reg_bank: RTL and testbench
================================

# coef_reg_bank

Parametrised bank of DEPTH registers, each WIDTH bits, holding polynomial coefficients for the MAC datapath of the non-linear approximation engine. Entries load by addressed write or by a serial shift chain. They are read either randomly or as an auto-incrementing coefficient stream that feeds the MAC one term per cycle. It is the multi-entry, multi-mode successor to the single load-enable register used elsewhere in the MAC.

## Interface
- WIDTH, 8, bits per entry (≥1)
- DEPTH, 4, number of entries (≥2; need not be a power of two)
- AW, $clog2(DEPTH), derived localparam, address/pointer width; not overridable
- clk_n  in  1  clock; all state updates on the falling edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear of all entries and the sequencer
- wr_en  in  1  addressed write strobe
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- sh_en  in  1  shift-chain strobe
- sh_in  in  WIDTH  data shifted into entry 0
- sh_out  out  WIDTH  entry[DEPTH-1] (combinational from state)
- rd_addr  in  AW  random-read address
- rd_data  out  WIDTH  entry[rd_addr], combinational; 0 if rd_addr ≥ DEPTH
- seq_start  in  1  start or restart the coefficient stream at entry 0
- seq_next  in  1  advance the stream
- seq_valid  out  1  stream active, seq_data meaningful
- seq_data  out  WIDTH  entry[ptr] when seq_valid, else 0 (combinational from state)
- seq_last  out  1  seq_valid && ptr == DEPTH-1
- err  out  1  one-cycle pulse flagging a dropped write

## Operation
- Entry update priority per falling edge: clr > sh_en > wr_en.
  - clr: all entries 0, ptr 0, seq_valid 0.
  - sh_en: entry[0] ← sh_in; entry[i] ← entry[i-1] for i = 1..DEPTH-1.
  - wr_en alone: entry[wr_addr] ← wr_data if wr_addr < DEPTH.
  - Unaddressed entries hold.
- err = 1 for one cycle after an edge where:
  - wr_en was asserted with wr_addr ≥ DEPTH; or
  - wr_en coincided with sh_en, so the write was dropped.
  - A coincident clr does not raise err.
- Sequencer (ptr, seq_valid), priority clr > seq_start > seq_next:
  - seq_start: ptr ← 0, seq_valid ← 1. Legal while already active; restarts the stream.
  - seq_next with seq_valid = 1 and ptr < DEPTH-1: ptr ← ptr+1.
  - seq_next with seq_valid = 1 and ptr == DEPTH-1: seq_valid ← 0, ptr ← 0. The stream ends; there is no wrap.
  - seq_next with seq_valid = 0: ignored.
- seq_data tracks entry contents live. A write or shift to entry[ptr] during streaming is visible at seq_data after that edge.

## Timing
- Reset (rst_n low, no clock needed):
  - all entries 0, ptr 0, seq_valid 0, err 0
  - hence rd_data, sh_out, seq_data and seq_last are all 0
- Write/shift latency: data visible on rd_data/sh_out/seq_data immediately after the capturing falling edge.
- seq_start to first coefficient: seq_valid = 1 and seq_data = entry[0] after 1 falling edge.
- Full stream: DEPTH cycles of seq_valid with seq_next held high. seq_last is high in the final cycle; seq_valid drops at the next edge.
- rst_n assertion mid-stream aborts immediately. Deassertion leaves the block idle; seq_start is required to resume.

## Structure
- No shared package types are required. The default coefficient width constant belongs in the project's MAC package and is passed as WIDTH by the instantiating module.
- One sub-module is natural: coef_seq_ctr, the ptr/seq_valid counter with start/next/clr inputs and a last output, parametrised by DEPTH.
- Storage is an array of WIDTH-bit registers in the top module.

## Test plan
- Reset then idle, WIDTH=8 DEPTH=4:
  - → rd_data, sh_out, seq_data = 0
  - → seq_valid, seq_last, err = 0
- Addressed writes 0x11, 0x22, 0x33, 0x44 to addresses 0–3, then read addresses 0–3 → 0x11, 0x22, 0x33, 0x44.
- Four shifts of 0xA0, 0xA1, 0xA2, 0xA3 → entry0 = 0xA3, entry3 = 0xA0, sh_out = 0xA0.
- Stream after the addressed writes, seq_start then seq_next held high:
  - → seq_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles
  - → seq_last high only on 0x44, then seq_valid = 0
- Restart mid-stream: seq_start asserted on the 0x22 cycle → next cycle seq_data = 0x11.
- Collisions, DEPTH=5 (AW=3):
  - wr_en with wr_addr 5 → no entry changes; err high for 1 cycle
  - wr_en together with sh_en → shift occurs, write dropped, err pulses
  - clr together with wr_en → all entries 0, err = 0

Source files
------------

// File: rtl/coef_reg_bank_pkg.sv
// coef_reg_bank_pkg: default sizing shared by the coefficient bank files
package coef_reg_bank_pkg;
  localparam int COEF_W = 8;
  localparam int COEF_DEPTH = 4;
endpackage

// File: rtl/coef_reg_bank_if.sv
// coef_reg_bank_if: load, read and stream signals of the coefficient bank
interface coef_reg_bank_if
  import coef_reg_bank_pkg::*;
#(parameter int WIDTH = COEF_W, parameter int DEPTH = COEF_DEPTH) ();
  localparam int AW = $clog2(DEPTH);
  logic clr, wr_en, sh_en, seq_start, seq_next, seq_valid, seq_last, err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [WIDTH-1:0] wr_data, sh_in, sh_out, rd_data, seq_data;
  modport master(
    output clr, wr_en, wr_addr, wr_data, sh_en, sh_in, rd_addr, seq_start, seq_next,
    input sh_out, rd_data, seq_valid, seq_data, seq_last, err
  );
  modport slave(
    input clr, wr_en, wr_addr, wr_data, sh_en, sh_in, rd_addr, seq_start, seq_next,
    output sh_out, rd_data, seq_valid, seq_data, seq_last, err
  );
endinterface

// File: rtl/coef_seq_ctr.sv
// coef_seq_ctr: pointer and active flag of the coefficient stream
module coef_seq_ctr
  import coef_reg_bank_pkg::*;
#(parameter int DEPTH = COEF_DEPTH, localparam int AW = $clog2(DEPTH)) (
  input  logic          clk_n,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          start,
  input  logic          next,
  output logic [AW-1:0] ptr,
  output logic          valid,
  output logic          last
);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  assign last = valid && ptr == LAST_PTR;
  // clr beats start beats next; stepping past the last entry ends the stream
  always_ff @(negedge clk_n or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      ptr <= '0;
      valid <= 1'b0;
    end else if (start) begin
      ptr <= '0;
      valid <= 1'b1;
    end else if (next && valid) begin
      ptr <= last ? '0 : ptr + AW'(1);
      valid <= !last;
    end
endmodule

// File: rtl/coef_reg_bank.sv
// coef_reg_bank: coefficient register bank with addressed, shift and stream access
module coef_reg_bank
  import coef_reg_bank_pkg::*;
#(parameter int WIDTH = COEF_W, parameter int DEPTH = COEF_DEPTH) (
  input logic            clk_n,
  input logic            rst_n,
  coef_reg_bank_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  logic wr_ok;
  assign wr_ok = {1'b0, bus.wr_addr} < DEPTH_W;
  coef_seq_ctr #(.DEPTH(DEPTH)) u_seq (
    .clk_n (clk_n),
    .rst_n (rst_n),
    .clr   (bus.clr),
    .start (bus.seq_start),
    .next  (bus.seq_next),
    .ptr   (ptr),
    .valid (bus.seq_valid),
    .last  (bus.seq_last)
  );
  // storage: clr beats shift beats addressed write; other entries hold
  always_ff @(negedge clk_n or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.sh_en) begin
      mem[0] <= bus.sh_in;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end else if (bus.wr_en && wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  // err pulses when a write is lost to a shift or an out-of-range address
  always_ff @(negedge clk_n or negedge rst_n)
    if (!rst_n) bus.err <= 1'b0;
    else bus.err <= !bus.clr && bus.wr_en && (bus.sh_en || !wr_ok);
  // read ports are live views of the stored entries
  always_comb begin
    bus.rd_data = {1'b0, bus.rd_addr} < DEPTH_W ? mem[bus.rd_addr] : '0;
    bus.sh_out = mem[DEPTH-1];
    bus.seq_data = bus.seq_valid ? mem[ptr] : '0;
  end
endmodule

// File: tb/tb_coef_reg_bank.sv
// tb_coef_reg_bank: directed and randomized checks of the coefficient bank
module tb_coef_reg_bank;
  logic clk_n = 1'b1;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  coef_reg_bank_if #(.WIDTH(8), .DEPTH(4)) b4 ();
  coef_reg_bank_if #(.WIDTH(8), .DEPTH(5)) b5 ();
  coef_reg_bank #(.WIDTH(8), .DEPTH(4)) u4 (.clk_n(clk_n), .rst_n(rst_n), .bus(b4.slave));
  coef_reg_bank #(.WIDTH(8), .DEPTH(5)) u5 (.clk_n(clk_n), .rst_n(rst_n), .bus(b5.slave));
  always #5 clk_n = ~clk_n;

  task automatic idle();
    b4.clr = 0; b4.wr_en = 0; b4.wr_addr = '0; b4.wr_data = '0; b4.sh_en = 0; b4.sh_in = '0;
    b4.rd_addr = '0; b4.seq_start = 0; b4.seq_next = 0;
    b5.clr = 0; b5.wr_en = 0; b5.wr_addr = '0; b5.wr_data = '0; b5.sh_en = 0; b5.sh_in = '0;
    b5.rd_addr = '0; b5.seq_start = 0; b5.seq_next = 0;
  endtask

  task automatic step();
    @(negedge clk_n);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #2;
    tests++; if (b4.rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data got %h want 00", b4.rd_data); end
    tests++; if (b4.sh_out !== 8'h00) begin fails++; $display("FAIL reset_sh_out got %h want 00", b4.sh_out); end
    tests++; if (b4.seq_data !== 8'h00) begin fails++; $display("FAIL reset_seq_data got %h want 00", b4.seq_data); end
    tests++; if (b4.seq_valid !== 1'b0) begin fails++; $display("FAIL reset_seq_valid got %b want 0", b4.seq_valid); end
    tests++; if (b4.seq_last !== 1'b0) begin fails++; $display("FAIL reset_seq_last got %b want 0", b4.seq_last); end
    tests++; if (b4.err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", b4.err); end
    tests++; if (b5.sh_out !== 8'h00) begin fails++; $display("FAIL reset5_sh_out got %h want 00", b5.sh_out); end
    @(posedge clk_n);
    rst_n = 1;
    step();
    tests++; if (b4.seq_valid !== 1'b0 || b4.err !== 1'b0) begin fails++; $display("FAIL idle_after_reset got valid=%b err=%b want 0 0", b4.seq_valid, b4.err); end
  endtask

  task automatic test_writes();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      b4.wr_en = 1; b4.wr_addr = 2'(i); b4.wr_data = 8'((i + 1) * 17);
      step();
    end
    b4.wr_en = 0;
    for (int i = 0; i < 4; i++) begin
      b4.rd_addr = 2'(i);
      #1;
      exp = 8'((i + 1) * 17);
      tests++; if (b4.rd_data !== exp) begin fails++; $display("FAIL write_read[%0d] got %h want %h", i, b4.rd_data, exp); end
    end
  endtask

  task automatic test_stream();
    logic [7:0] exp;
    b4.seq_start = 1;
    step();
    b4.seq_start = 0;
    b4.seq_next = 1;
    for (int k = 0; k < 4; k++) begin
      exp = 8'((k + 1) * 17);
      tests++; if (b4.seq_valid !== 1'b1 || b4.seq_data !== exp) begin fails++; $display("FAIL stream[%0d] got valid=%b data=%h want 1 %h", k, b4.seq_valid, b4.seq_data, exp); end
      tests++; if (b4.seq_last !== (k == 3)) begin fails++; $display("FAIL stream_last[%0d] got %b want %b", k, b4.seq_last, k == 3); end
      step();
    end
    tests++; if (b4.seq_valid !== 1'b0 || b4.seq_data !== 8'h00) begin fails++; $display("FAIL stream_end got valid=%b data=%h want 0 00", b4.seq_valid, b4.seq_data); end
    step();
    tests++; if (b4.seq_valid !== 1'b0) begin fails++; $display("FAIL stream_no_wrap got valid=%b want 0", b4.seq_valid); end
  endtask

  task automatic test_restart();
    b4.seq_start = 1; b4.seq_next = 1;
    step();
    b4.seq_start = 0;
    step();
    tests++; if (b4.seq_data !== 8'h22) begin fails++; $display("FAIL restart_pre got %h want 22", b4.seq_data); end
    b4.seq_start = 1;
    step();
    tests++; if (b4.seq_valid !== 1'b1 || b4.seq_data !== 8'h11) begin fails++; $display("FAIL restart got valid=%b data=%h want 1 11", b4.seq_valid, b4.seq_data); end
    b4.seq_start = 0; b4.seq_next = 0;
    step();
    tests++; if (b4.seq_data !== 8'h11) begin fails++; $display("FAIL hold_no_next got %h want 11", b4.seq_data); end
  endtask

  task automatic test_reset_abort();
    #2;
    rst_n = 0;
    #1;
    tests++; if (b4.seq_valid !== 1'b0 || b4.seq_data !== 8'h00) begin fails++; $display("FAIL abort got valid=%b data=%h want 0 00", b4.seq_valid, b4.seq_data); end
    tests++; if (b4.rd_data !== 8'h00) begin fails++; $display("FAIL abort_entries got %h want 00", b4.rd_data); end
    @(posedge clk_n);
    rst_n = 1;
    step();
    tests++; if (b4.seq_valid !== 1'b0) begin fails++; $display("FAIL abort_idle got %b want 0", b4.seq_valid); end
  endtask

  task automatic test_shift();
    for (int i = 0; i < 4; i++) begin
      b4.sh_en = 1; b4.sh_in = 8'(8'hA0 + i);
      step();
    end
    b4.sh_en = 0;
    b4.rd_addr = 2'd0;
    #1;
    tests++; if (b4.rd_data !== 8'hA3) begin fails++; $display("FAIL shift_entry0 got %h want a3", b4.rd_data); end
    b4.rd_addr = 2'd3;
    #1;
    tests++; if (b4.rd_data !== 8'hA0) begin fails++; $display("FAIL shift_entry3 got %h want a0", b4.rd_data); end
    tests++; if (b4.sh_out !== 8'hA0) begin fails++; $display("FAIL shift_sh_out got %h want a0", b4.sh_out); end
  endtask

  task automatic test_collisions();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) begin
      b5.wr_en = 1; b5.wr_addr = 3'(i); b5.wr_data = 8'(8'h50 + i);
      step();
    end
    b5.wr_addr = 3'd5; b5.wr_data = 8'hFF;
    step();
    b5.wr_en = 0;
    tests++; if (b5.err !== 1'b1) begin fails++; $display("FAIL oob_err got %b want 1", b5.err); end
    for (int i = 0; i < 5; i++) begin
      b5.rd_addr = 3'(i);
      #1;
      exp = 8'(8'h50 + i);
      tests++; if (b5.rd_data !== exp) begin fails++; $display("FAIL oob_hold[%0d] got %h want %h", i, b5.rd_data, exp); end
    end
    b5.rd_addr = 3'd5;
    #1;
    tests++; if (b5.rd_data !== 8'h00) begin fails++; $display("FAIL oob_read got %h want 00", b5.rd_data); end
    step();
    tests++; if (b5.err !== 1'b0) begin fails++; $display("FAIL err_one_cycle got %b want 0", b5.err); end
    b5.wr_en = 1; b5.wr_addr = 3'd2; b5.wr_data = 8'hFF; b5.sh_en = 1; b5.sh_in = 8'h77;
    step();
    b5.wr_en = 0; b5.sh_en = 0;
    tests++; if (b5.err !== 1'b1) begin fails++; $display("FAIL wr_sh_err got %b want 1", b5.err); end
    b5.rd_addr = 3'd0;
    #1;
    tests++; if (b5.rd_data !== 8'h77) begin fails++; $display("FAIL wr_sh_entry0 got %h want 77", b5.rd_data); end
    b5.rd_addr = 3'd2;
    #1;
    tests++; if (b5.rd_data !== 8'h51) begin fails++; $display("FAIL wr_sh_entry2 got %h want 51", b5.rd_data); end
    tests++; if (b5.sh_out !== 8'h53) begin fails++; $display("FAIL wr_sh_sh_out got %h want 53", b5.sh_out); end
    b5.clr = 1; b5.wr_en = 1; b5.wr_addr = 3'd6; b5.wr_data = 8'hEE;
    step();
    b5.clr = 0; b5.wr_en = 0;
    tests++; if (b5.err !== 1'b0) begin fails++; $display("FAIL clr_wr_err got %b want 0", b5.err); end
    for (int i = 0; i < 5; i++) begin
      b5.rd_addr = 3'(i);
      #1;
      tests++; if (b5.rd_data !== 8'h00) begin fails++; $display("FAIL clr_entry[%0d] got %h want 00", i, b5.rd_data); end
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] e_rd, e_data;
    int pos;
    bit act, e_err;
    idle();
    b5.clr = 1;
    step();
    b5.clr = 0;
    q = {};
    repeat (5) q.push_back(8'h00);
    pos = 0;
    act = 0;
    for (int n = 0; n < 300; n++) begin
      b5.clr = ($urandom_range(0, 29) == 0);
      b5.sh_en = ($urandom_range(0, 3) == 0);
      b5.wr_en = ($urandom_range(0, 1) == 1);
      b5.wr_addr = 3'($urandom_range(0, 7));
      b5.wr_data = 8'($urandom);
      b5.sh_in = 8'($urandom);
      b5.rd_addr = 3'($urandom_range(0, 7));
      b5.seq_start = ($urandom_range(0, 7) == 0);
      b5.seq_next = ($urandom_range(0, 2) != 0);
      e_err = !b5.clr && b5.wr_en && (b5.sh_en || b5.wr_addr > 3'd4);
      if (b5.clr) begin
        foreach (q[i]) q[i] = 8'h00;
        act = 0;
        pos = 0;
      end else begin
        if (b5.sh_en) begin
          q.push_front(b5.sh_in);
          void'(q.pop_back());
        end else if (b5.wr_en && b5.wr_addr < 3'd5) begin
          q[b5.wr_addr] = b5.wr_data;
        end
        if (b5.seq_start) begin
          act = 1;
          pos = 0;
        end else if (b5.seq_next && act) begin
          if (pos == 4) begin
            act = 0;
            pos = 0;
          end else pos++;
        end
      end
      step();
      e_rd = b5.rd_addr < 3'd5 ? q[b5.rd_addr] : 8'h00;
      e_data = act ? q[pos] : 8'h00;
      tests++; if (b5.rd_data !== e_rd) begin fails++; $display("FAIL rand_rd[%0d] got %h want %h", n, b5.rd_data, e_rd); end
      tests++; if (b5.sh_out !== q[4]) begin fails++; $display("FAIL rand_sh_out[%0d] got %h want %h", n, b5.sh_out, q[4]); end
      tests++; if (b5.seq_valid !== act) begin fails++; $display("FAIL rand_valid[%0d] got %b want %b", n, b5.seq_valid, act); end
      tests++; if (b5.seq_data !== e_data) begin fails++; $display("FAIL rand_seq_data[%0d] got %h want %h", n, b5.seq_data, e_data); end
      tests++; if (b5.seq_last !== (act && pos == 4)) begin fails++; $display("FAIL rand_last[%0d] got %b want %b", n, b5.seq_last, act && pos == 4); end
      tests++; if (b5.err !== e_err) begin fails++; $display("FAIL rand_err[%0d] got %b want %b", n, b5.err, e_err); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_writes();
    test_stream();
    test_restart();
    test_reset_abort();
    test_shift();
    test_collisions();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
